oagu_add: RTL

Output address generator and write-back controller for ADD mode. Accepts result beats from the element-wise add unit through a valid/ready handshake, buffers them in a 2-entry skid FIFO, and writes them to the IO buffer at consecutive addresses starting at a decoder-supplied base. Iterates col → piece → row over the output tensor and pulses done after the last write. It is the write-side counterpart of the ADD-mode input address generator.

---
 rtl/oagu_add_if.sv | 23 ++
 rtl/oagu_add.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/oagu_add_if.sv
// Result-beat input stream and IO-buffer write port of the ADD-mode output
// address generator. The slave modport is the generator's view.
interface oagu_add_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] i_data;
    logic              i_valid;
    logic              o_ready;
    logic              i_wr_ready;
    logic [12:0]       o_wr_addr;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_wr_en;

    modport slave (
        input  i_data, i_valid, i_wr_ready,
        output o_ready, o_wr_addr, o_wr_data, o_wr_en
    );

    modport master (
        output i_data, i_valid, i_wr_ready,
        input  o_ready, o_wr_addr, o_wr_data, o_wr_en
    );
endinterface

// File: rtl/oagu_add.sv
// ADD-mode output address generator / write-back controller.
// Buffers result beats in a 2-entry skid FIFO and writes them to the IO
// buffer at consecutive (wrapping) addresses, walking col -> piece -> row.
//
// state  | meaning
// IDLE   | waiting for start_calculate
// WRITE  | accepting beats and issuing writes
// FINISH | last write issued (or empty config); o_done follows next cycle
module oagu_add #(
    parameter int DATA_W = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_calculate,
    input  logic [12:0] addr_start_o,
    input  logic [7:0]  out_x_length,
    input  logic [7:0]  out_y_length,
    input  logic [7:0]  in_piece,
    oagu_add_if.slave   bus,
    output logic        o_done,
    output logic        o_err
);
    typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;

    state_t            state_q, state_d;
    logic [7:0]        x_len_q, y_len_q, p_len_q;
    logic [7:0]        col_q, piece_q, row_q;
    logic [12:0]       addr_q;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;
    logic              wr_en_q;
    logic [12:0]       wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic zero_cfg, load, accept, issue, last_issue;
    logic col_end, piece_end, row_end;

    // A start in FINISH is not honoured; the pass completes first.
    assign load      = start_calculate && (state_q != FINISH);
    assign zero_cfg  = (out_x_length == 8'd0) || (out_y_length == 8'd0) || (in_piece == 8'd0);
    assign col_end   = (col_q == x_len_q - 8'd1);
    assign piece_end = (piece_q == p_len_q - 8'd1);
    assign row_end   = (row_q == y_len_q - 8'd1);

    assign bus.o_ready = (state_q == WRITE) && (count_q != 2'd2);
    // start_calculate wins over a same-cycle accept or issue.
    assign accept      = bus.i_valid && bus.o_ready && !start_calculate;
    assign issue       = (state_q == WRITE) && (count_q != 2'd0) && bus.i_wr_ready && !start_calculate;
    assign last_issue  = issue && col_end && piece_end && row_end;

    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_wr_addr = wr_addr_q;
    assign bus.o_wr_data = wr_data_q;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_calculate) state_d = zero_cfg ? FINISH : WRITE;
            end
            WRITE: begin
                if (start_calculate)  state_d = zero_cfg ? FINISH : WRITE;
                else if (last_issue)  state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the pass configuration on start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_len_q <= 8'd0;
            y_len_q <= 8'd0;
            p_len_q <= 8'd0;
        end else if (load) begin
            x_len_q <= out_x_length;
            y_len_q <= out_y_length;
            p_len_q <= in_piece;
        end
    end

    // Address and col/piece/row iteration, advanced once per issued write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= 13'd0;
            col_q   <= 8'd0;
            piece_q <= 8'd0;
            row_q   <= 8'd0;
        end else if (load) begin
            addr_q  <= addr_start_o;
            col_q   <= 8'd0;
            piece_q <= 8'd0;
            row_q   <= 8'd0;
        end else if (issue) begin
            addr_q <= addr_q + 13'd1;
            if (col_end) begin
                col_q <= 8'd0;
                if (piece_end) begin
                    piece_q <= 8'd0;
                    row_q   <= row_q + 8'd1;
                end else begin
                    piece_q <= piece_q + 8'd1;
                end
            end else begin
                col_q <= col_q + 8'd1;
            end
        end
    end

    // Skid FIFO pointers and occupancy; a start flushes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (load) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (accept) wr_ptr_q <= ~wr_ptr_q;
            if (issue)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, accept} - {1'b0, issue};
        end
    end

    // Skid FIFO storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr_q] <= bus.i_data;
    end

    // Registered write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= 13'd0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= issue;
            if (issue) begin
                wr_addr_q <= addr_q;
                wr_data_q <= fifo_mem[rd_ptr_q];
            end
        end
    end

    // Done pulse lands the cycle after FINISH; error flag is sticky per pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
        end else begin
            o_done <= (state_q == FINISH);
            if (load)                                     o_err <= zero_cfg;
            else if (bus.i_valid && (state_q != WRITE))   o_err <= 1'b1;
        end
    end
endmodule
